// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and width helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      RESET,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Index width that never collapses to zero bits.
   function automatic int clog2w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; shared by the UART transmit and receive paths.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = clog2w(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_data,
   output logic [W-1:0]  o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_push, w_pop;

   // A push into a full FIFO is legal only when a pop frees the slot on the same edge.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

   assign o_data  = r_mem[r_rp];
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with queued input: runtime divisor, optional parity, 1/2 stop bits,
// frames sent back-to-back while the queue holds characters.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   input  logic [DIV_W-1:0]  i_baud_div,
   input  logic [1:0]        i_parity,
   input  logic              i_two_stop,
   output logic              o_tx,
   output logic              o_busy
);

   localparam int CW = clog2w(FIFO_DEPTH);
   localparam int BW = clog2w(DATA_W);

   state_t            r_state;
   logic [DIV_W-1:0]  r_div, r_bcnt;
   logic [DATA_W-1:0] r_shift;
   logic [BW-1:0]     r_bit;
   logic              r_par_en, r_par_bit, r_two, r_stop2;
   logic              r_tx, r_ready, r_busy;

   logic              w_push, w_pop, w_full, w_empty, w_bit_end, w_stop_done;
   logic [DATA_W-1:0] w_head;
   logic [CW:0]       w_count, w_cnt_nxt;
   logic [DIV_W-1:0]  w_div;

   assign w_bit_end   = (r_bcnt == r_div);
   assign w_stop_done = (r_state == STOP) && w_bit_end && (!r_two || r_stop2);
   assign w_push      = i_valid && r_ready && !w_full;
   assign w_pop       = !w_empty && ((r_state == IDLE) || w_stop_done);
   assign w_cnt_nxt   = w_count + (CW+1)'(w_push) - (CW+1)'(w_pop);
   assign w_div       = (i_baud_div > DIV_W'(1)) ? i_baud_div : DIV_W'(1);

   uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (i_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= RESET;
         r_tx      <= 1'b1;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_div     <= DIV_W'(1);
         r_bcnt    <= DIV_W'(1);
         r_shift   <= '0;
         r_bit     <= '0;
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
         r_two     <= 1'b0;
         r_stop2   <= 1'b0;
      end else begin
         r_ready <= (w_cnt_nxt != (CW+1)'(FIFO_DEPTH));
         r_bcnt  <= w_bit_end ? DIV_W'(1) : r_bcnt + 1'b1;
         // Frame start, from IDLE or straight out of the last stop bit; config is frozen here.
         if (w_pop) begin
            r_state   <= START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_shift   <= w_head;
            r_div     <= w_div;
            r_bcnt    <= DIV_W'(1);
            r_par_en  <= (i_parity == PAR_EVEN) || (i_parity == PAR_ODD);
            r_par_bit <= (^w_head) ^ (i_parity == PAR_ODD);
            r_two     <= i_two_stop;
            r_stop2   <= 1'b0;
         end else begin
            case (r_state)
               RESET: r_state <= IDLE;
               START: if (w_bit_end) begin
                  r_state <= DATA;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_bit   <= '0;
               end
               DATA: if (w_bit_end) begin
                  if (r_bit == BW'(DATA_W-1)) begin
                     r_state <= r_par_en ? PARITY : STOP;
                     r_tx    <= r_par_en ? r_par_bit : 1'b1;
                  end else begin
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                     r_bit   <= r_bit + 1'b1;
                  end
               end
               PARITY: if (w_bit_end) begin
                  r_state <= STOP;
                  r_tx    <= 1'b1;
               end
               STOP: if (w_bit_end) begin
                  if (r_two && !r_stop2) begin
                     r_stop2 <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_tx    = r_tx;
   assign o_ready = r_ready;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle plus directed literal frames.
module tb_uart_tx_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [7:0]  data = '0;
   logic        ready;
   logic [15:0] baud = 16'd4;
   logic [1:0]  par = 2'b00;
   logic        two = 1'b0;
   logic        tx, busy;
   logic        valid5 = 1'b0;
   logic [4:0]  data5 = '0;
   logic        ready5, tx5, busy5;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_W(8), .DIV_W(16), .FIFO_DEPTH(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(ready),
      .i_baud_div(baud), .i_parity(par), .i_two_stop(two), .o_tx(tx), .o_busy(busy)
   );

   uart_tx_fifo #(.DATA_W(5), .DIV_W(16), .FIFO_DEPTH(4)) dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid5), .i_data(data5), .o_ready(ready5),
      .i_baud_div(baud), .i_parity(par), .i_two_stop(two), .o_tx(tx5), .o_busy(busy5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: characters waiting in a queue, the line as a per-cycle list of levels.
   logic [7:0] mq[$];
   bit         wq[$];
   logic       e_tx = 1'b1, e_rdy = 1'b0, e_busy = 1'b0;
   logic       m_acc;

   task automatic build(input logic [7:0] d);
      bit b[$];
      int dv;
      dv = (baud < 16'd2) ? 1 : int'(baud);
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(d[i]);
      if (par == 2'b01) b.push_back(^d);
      else if (par == 2'b10) b.push_back(~^d);
      b.push_back(1'b1);
      if (two) b.push_back(1'b1);
      foreach (b[i]) repeat (dv) wq.push_back(b[i]);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete(); wq.delete();
         e_tx = 1'b1; e_rdy = 1'b0; e_busy = 1'b0;
      end else begin
         m_acc = valid && e_rdy;
         if (wq.size() == 0 && mq.size() != 0) build(mq.pop_front());
         if (wq.size() != 0) begin
            e_tx = wq.pop_front(); e_busy = 1'b1;
         end else begin
            e_tx = 1'b1; e_busy = 1'b0;
         end
         if (m_acc) mq.push_back(data);
         e_rdy = (mq.size() < 4);
      end
   end

   always @(negedge clk) begin
      chk("cyc_tx", tx, e_tx);
      chk("cyc_ready", ready, e_rdy);
      chk("cyc_busy", busy, e_busy);
   end

   // One frame into an idle block; xb holds the expected bit levels in line order.
   task automatic frame(input bit s5, input logic [7:0] d, input logic [15:0] dv,
                        input logic [15:0] dv_chg, input logic [11:0] xb, input int nb,
                        input int xlen, input string nm);
      int n, bd;
      bd = (dv < 16'd2) ? 1 : int'(dv);
      baud = dv;
      if (s5) begin valid5 = 1'b1; data5 = d[4:0]; end
      else    begin valid  = 1'b1; data  = d;      end
      @(posedge clk); #1;
      valid = 1'b0; valid5 = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while ((s5 ? busy5 : busy) && n < 400) begin
         if (n == 1) baud = dv_chg;
         if ((n % bd) == (bd / 2) && (n / bd) < nb) begin
            chk({nm, "_bit"}, s5 ? tx5 : tx, xb[n/bd]);
            if (!s5) chk({nm, "_model"}, e_tx, xb[n/bd]);
         end
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_len"}, n, xlen);
      baud = 16'd4;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, k, lows;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_tx", tx, 1); chk("rst_ready", ready, 0); chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      #1 chk("reset_state_ready", ready, 0);
      @(posedge clk); #1;
      chk("ready_after_rst", ready, 1);

      frame(0, 8'h55, 16'd4, 16'd4, 12'h2AA, 10, 40, "f55");
      par = 2'b01;
      frame(0, 8'h03, 16'd4, 16'd4, 12'h406, 11, 44, "even");
      par = 2'b10; two = 1'b1;
      frame(0, 8'h03, 16'd4, 16'd4, 12'hE06, 12, 48, "odd2");
      par = 2'b00; two = 1'b0;
      frame(0, 8'hA5, 16'd0, 16'd9, 12'h34A, 10, 10, "div0");
      frame(1, 8'h15, 16'd0, 16'd7, 12'h06A, 7, 7, "w5n1");

      // Six consecutive writes: the fifth fills the queue, the sixth is dropped.
      for (int i = 0; i < 6; i++) begin
         valid = 1'b1; data = 8'hA1 + 8'(i);
         @(posedge clk); #1;
         chk("burst_ready", ready, (i < 4) ? 1 : 0);
      end
      valid = 1'b0;
      n = 0;
      while (busy && n < 1000) begin @(posedge clk); #1; n++; end
      chk("burst_len", n, 196);

      // Keep writing against a full queue; each character waits until space opens.
      k = 0;
      for (int i = 0; i < 6; i++) begin
         valid = 1'b1; data = 8'hB0 + 8'(i);
         while (!ready && k < 2000) begin @(posedge clk); #1; k++; end
         @(posedge clk); #1;
      end
      valid = 1'b0;
      chk("hold_timeout", (k >= 2000) ? 1 : 0, 0);
      n = 0;
      while (busy && n < 2000) begin @(posedge clk); #1; n++; end
      chk("hold_drain_timeout", (n >= 2000) ? 1 : 0, 0);

      // Reset during the data bits of a frame with another character queued.
      valid = 1'b1; data = 8'h00;
      @(posedge clk); #1;
      data = 8'h7E;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("pre_rst_tx", tx, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_tx", tx, 1); chk("midrst_ready", ready, 0); chk("midrst_busy", busy, 0);
      #12 rst_n = 1'b1;
      lows = 0; n = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (tx === 1'b0) lows++;
         if (busy === 1'b1) n++;
      end
      chk("post_rst_tx_low", lows, 0);
      chk("post_rst_busy", n, 0);
      chk("post_rst_ready", ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
